// File: rtl/conv_pkg.sv
// Shared types and constants for the streaming KxK convolution.
// The default kernel is a KxK box filter of unit weights.
package conv_pkg;
  localparam int DIM_DEF   = 28;
  localparam int K_DEF     = 5;
  localparam int SHIFT_DEF = 5;

  typedef logic [7:0]        pixel_t;
  typedef logic signed [7:0] weight_t;

  localparam int ACC_W = 8 + 8 + $clog2(K_DEF * K_DEF);

  // Packed so it can be overridden as a single top-level parameter.
  localparam weight_t [K_DEF-1:0][K_DEF-1:0] KERNEL = {(K_DEF*K_DEF){8'sd1}};
endpackage

// File: rtl/conv_line_buffer.sv
// DIM-deep pixel delay line; dout is the pixel written DIM enabled cycles earlier,
// i.e. the same column one row up when fed with a raster stream.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int DIM = DIM_DEF
) (
  input  logic   clk,
  input  logic   en,
  input  pixel_t din,
  output pixel_t dout
);

  pixel_t mem [DIM];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DIM; i++) mem[i] <= mem[i-1];
    end
  end

  assign dout = mem[DIM-1];

endmodule

// File: rtl/conv.sv
// Streaming KxK "valid" convolution over a DIMxDIM raster frame, one pixel per clock.
// Define CONV_SATURATE_EN to clamp results to 0..255 instead of truncating to 8 bits.
module conv
  import conv_pkg::*;
#(
  parameter int DIM   = DIM_DEF,
  parameter int K     = K_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter weight_t [K-1:0][K-1:0] WEIGHTS = KERNEL
) (
  input  logic   clk,
  input  logic   reset,
  input  pixel_t pxl_in,
  output pixel_t pxl_out,
  output logic   pxl_valid
);

  localparam int AW = 16 + $clog2(K * K);
  localparam int CW = $clog2(DIM);

  logic [CW-1:0] row, col;

  // tap[K-1] is the live pixel; tap[0] is the same column K-1 rows up.
  pixel_t tap [K];
  pixel_t hist [K][K-1];

  assign tap[K-1] = pxl_in;

  for (genvar g = 0; g < K-1; g++) begin : g_lb
    conv_line_buffer #(.DIM(DIM)) u_lb (
      .clk  (clk),
      .en   (1'b1),
      .din  (tap[K-1-g]),
      .dout (tap[K-2-g])
    );
  end

  function automatic logic signed [AW-1:0] mac_term(input pixel_t p, input weight_t w);
    logic signed [AW-1:0] pe, we;
    pe = AW'(p);
    we = AW'(w);
    return pe * we;
  endfunction

  function automatic pixel_t fit(input logic signed [AW-1:0] v);
`ifdef CONV_SATURATE_EN
    if (v[AW-1])          return 8'h00;
    else if (|v[AW-2:8])  return 8'hFF;
    else                  return v[7:0];
`else
    return v[7:0];
`endif
  endfunction

  // Window history: columns 0..K-2 of each row, oldest column at index 0.
  always_ff @(posedge clk) begin
    for (int i = 0; i < K; i++) begin
      hist[i][K-2] <= tap[i];
      for (int j = 0; j < K-2; j++) hist[i][j] <= hist[i][j+1];
    end
  end

  logic signed [AW-1:0] acc, res;
  logic                 win_ok;

  always_comb begin
    acc = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K-1; j++) acc = acc + mac_term(hist[i][j], WEIGHTS[i][j]);
      acc = acc + mac_term(tap[i], WEIGHTS[i][K-1]);
    end
    res    = acc >>> SHIFT;
    win_ok = (row >= CW'(K-1)) && (col >= CW'(K-1));
  end

  // Output stage: counters, valid and result register
  always_ff @(posedge clk) begin
    if (!reset) begin
      row       <= '0;
      col       <= '0;
      pxl_out   <= '0;
      pxl_valid <= 1'b0;
    end else begin
      pxl_valid <= win_ok;
      if (win_ok) pxl_out <= fit(res);
      if (col == CW'(DIM-1)) begin
        col <= '0;
        row <= (row == CW'(DIM-1)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv.sv
// Self-checking bench: three conv instances (box/SHIFT=5, box/SHIFT=0, centre -1/SHIFT=0)
// share one pixel stream and are compared against a frame-array reference model.
module tb_conv;
  import conv_pkg::*;

  localparam int D = 28;
  localparam int K = 5;
  localparam int PULSES = (D - K + 1) * (D - K + 1);
  localparam logic [199:0] NEG_W = 200'hFF << 96;

  logic   clk = 1'b0;
  logic   reset;
  pixel_t pxl_in;
  pixel_t out_a, out_b, out_c;
  logic   vld_a, vld_b, vld_c;

  always #5 clk = ~clk;

  conv #(.SHIFT(5)) dut_a (.clk(clk), .reset(reset), .pxl_in(pxl_in), .pxl_out(out_a), .pxl_valid(vld_a));
  conv #(.SHIFT(0)) dut_b (.clk(clk), .reset(reset), .pxl_in(pxl_in), .pxl_out(out_b), .pxl_valid(vld_b));
  conv #(.SHIFT(0), .WEIGHTS(NEG_W))
                    dut_c (.clk(clk), .reset(reset), .pxl_in(pxl_in), .pxl_out(out_c), .pxl_valid(vld_c));

  int checks = 0;
  int failures = 0;
  int fr [D][D];
  int r = 0, c = 0;
  int last [3];
  int pulses [3];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d (row=%0d col=%0d)", tag, got, exp, r, c);
    end
  endtask

  // kern 0: unit box filter; kern 1: centre weight -1, others 0.
  function automatic int model(input int kern, input int shift);
    int acc, w, res;
    acc = 0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) begin
        if (kern == 0) w = 1;
        else           w = (i == K/2 && j == K/2) ? -1 : 0;
        acc += w * fr[r-K+1+i][c-K+1+j];
      end
    res = acc >>> shift;
`ifdef CONV_SATURATE_EN
    if (res < 0) res = 0;
    if (res > 255) res = 255;
`else
    res = res & 255;
`endif
    return res;
  endfunction

  function automatic int pattern(input int kind, input int pr, input int pc);
    case (kind)
      0:       return 100;
      1:       return pc;
      2:       return 255;
      3:       return 50;
      default: return int'($urandom_range(255, 0));
    endcase
  endfunction

  task automatic drive(input int p);
    bit ok;
    pxl_in = pixel_t'(p);
    fr[r][c] = p;
    ok = (r >= K-1) && (c >= K-1);
    if (ok) begin
      last[0] = model(0, 5);
      last[1] = model(0, 0);
      last[2] = model(1, 0);
    end
    @(posedge clk);
    #1;
    check("vld_a", int'(vld_a), int'(ok));
    check("vld_b", int'(vld_b), int'(ok));
    check("vld_c", int'(vld_c), int'(ok));
    check("out_a", int'(out_a), last[0]);
    check("out_b", int'(out_b), last[1]);
    check("out_c", int'(out_c), last[2]);
    if (vld_a) pulses[0]++;
    if (vld_b) pulses[1]++;
    if (vld_c) pulses[2]++;
    if (c == D-1) begin
      c = 0;
      if (r == D-1) begin
        r = 0;
        check("pulses_a", pulses[0], PULSES);
        check("pulses_b", pulses[1], PULSES);
        check("pulses_c", pulses[2], PULSES);
        for (int k = 0; k < 3; k++) pulses[k] = 0;
      end else begin
        r++;
      end
    end else begin
      c++;
    end
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    pxl_in = pixel_t'($urandom_range(255, 0));
    @(posedge clk);
    #1;
    check("rst_out_a", int'(out_a), 0);
    check("rst_out_b", int'(out_b), 0);
    check("rst_out_c", int'(out_c), 0);
    check("rst_vld_a", int'(vld_a), 0);
    check("rst_vld_b", int'(vld_b), 0);
    check("rst_vld_c", int'(vld_c), 0);
    reset = 1'b1;
    r = 0;
    c = 0;
    for (int k = 0; k < 3; k++) begin
      last[k]   = 0;
      pulses[k] = 0;
    end
  endtask

  task automatic run_frame(input int kind, input int npix);
    for (int n = 0; n < npix; n++) drive(pattern(kind, r, c));
  endtask

  initial begin
    reset  = 1'b0;
    pxl_in = '0;
    @(posedge clk);
    #1;
    do_reset();

    run_frame(0, D*D);
    run_frame(1, D*D);
    run_frame(1, D*D);
    run_frame(2, D*D);
    run_frame(3, D*D);
    run_frame(4, 300);
    do_reset();
    run_frame(4, D*D);
    run_frame(4, D*D);
    run_frame(0, D*D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
